// File: rtl/risc_pkg.sv
// Shared definitions for the Simple-RISC controller: opcode and sequencer
// state encodings plus the ALU-operand opcode test.
package risc_pkg;

    typedef enum logic [2:0] {
        OpHlt = 3'b000,
        OpSkz = 3'b001,
        OpAdd = 3'b010,
        OpAnd = 3'b011,
        OpXor = 3'b100,
        OpLda = 3'b101,
        OpSto = 3'b110,
        OpJmp = 3'b111
    } opcode_e;

    // Low three bits of StP0..StP7 are the phase number.
    typedef enum logic [3:0] {
        StP0     = 4'd0,
        StP1     = 4'd1,
        StP2     = 4'd2,
        StP3     = 4'd3,
        StP4     = 4'd4,
        StP5     = 4'd5,
        StP6     = 4'd6,
        StP7     = 4'd7,
        StHalted = 4'd8
    } state_e;

    localparam logic [2:0] HaltedPhase = 3'd4;

    // Opcodes that read a memory operand into the ALU.
    function automatic logic is_aluop(input logic [2:0] op);
        return (op == OpAdd) || (op == OpAnd) || (op == OpXor) || (op == OpLda);
    endfunction

endpackage

// File: rtl/risc_phase_counter.sv
// Eight-phase sequencer register: advances one phase per clock, parks in
// StHalted when a HLT is seen in P4, and returns to P0 on reset.
module risc_phase_counter
    import risc_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   hlt,
    output state_e state
);

    state_e state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StP0;
        end else if (state_q == StHalted) begin
            state_q <= StHalted;
        end else if (state_q == StP4 && hlt) begin
            state_q <= StHalted;
        end else begin
            // 3-bit add wraps P7 back to P0.
            state_q <= state_e'({1'b0, state_q[2:0] + 3'd1});
        end
    end

    assign state = state_q;

endmodule

// File: rtl/risc_controller.sv
// Simple-RISC instruction sequencer: decodes control strobes from the phase
// and live opcode/zero inputs, and counts retired instructions.
module risc_controller
    import risc_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       opcode,
    input  logic             zero,
    output logic             sel,
    output logic             rd,
    output logic             ld_ir,
    output logic             inc_pc,
    output logic             halt,
    output logic             ld_pc,
    output logic             data_e,
    output logic             ld_ac,
    output logic             wr,
    output logic [2:0]       phase,
    output logic [CNT_W-1:0] instr_count
);

    state_e           state;
    logic             is_hlt;
    logic             aluop;
    logic [CNT_W-1:0] count_q;

    assign is_hlt = (opcode == OpHlt);
    assign aluop  = is_aluop(opcode);

    risc_phase_counter u_phase_counter (
        .clk   (clk),
        .rst   (rst),
        .hlt   (is_hlt),
        .state (state)
    );

    // Leaving P7 retires an instruction; HLT never gets there.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (state == StP7) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign instr_count = count_q;
    assign phase       = (state == StHalted) ? HaltedPhase : state[2:0];

    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        halt   = 1'b0;
        ld_pc  = 1'b0;
        data_e = 1'b0;
        ld_ac  = 1'b0;
        wr     = 1'b0;
        case (state)
            StP0: begin
                sel = 1'b1;
            end
            StP1: begin
                sel = 1'b1;
                rd  = 1'b1;
            end
            StP2, StP3: begin
                sel   = 1'b1;
                rd    = 1'b1;
                ld_ir = 1'b1;
            end
            StP4: begin
                inc_pc = 1'b1;
                halt   = is_hlt;
            end
            StP5: begin
                rd = aluop;
            end
            StP6: begin
                rd     = aluop;
                inc_pc = (opcode == OpSkz) && zero;
                ld_pc  = (opcode == OpJmp);
                data_e = (opcode == OpSto);
            end
            StP7: begin
                rd     = aluop;
                ld_ac  = aluop;
                ld_pc  = (opcode == OpJmp);
                wr     = (opcode == OpSto);
                data_e = (opcode == OpSto);
            end
            StHalted: begin
                halt = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/risc_controller.md
Name: risc_controller

Overview:
- 8-phase instruction sequencer for the Simple-RISC core.
- Steps fetch/decode/execute for each instruction and drives the control strobes for the PC, IR, memory, accumulator and the 8-bit ALU.
- Decodes the 3-bit opcode from the IR and the accumulator zero flag.
- Holds a halt state and a retired-instruction counter for debug.

Parameters:
- CNT_W, 8, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  3  current IR opcode (HLT=000 SKZ=001 ADD=010 AND=011 XOR=100 LDA=101 STO=110 JMP=111)
- zero  in  1  accumulator-is-zero flag
- sel  out  1  address mux: 1 = PC, 0 = IR operand address
- rd  out  1  memory read enable
- ld_ir  out  1  load instruction register
- inc_pc  out  1  increment PC
- halt  out  1  processor halted / halting
- ld_pc  out  1  load PC from IR operand (jump)
- data_e  out  1  drive accumulator onto data bus
- ld_ac  out  1  load accumulator from ALU result
- wr  out  1  memory write strobe
- phase  out  3  current phase 0-7 (debug)
- instr_count  out  CNT_W  retired instructions, wrapping

Behaviour:
- State: phases P0..P7 plus HALTED. On a clock edge with rst=1: state<=P0, instr_count<=0, regardless of current state, including mid-instruction or HALTED.
- Reset values (first cycle after reset, state P0): sel=1, all other strobes 0, phase=0, instr_count=0.
- Outputs are decoded combinationally from the state plus the live opcode/zero inputs. There are no registered strobe outputs.
- Transitions: P0->P1->...->P7->P0, one phase per clock. Exception: in P4, if opcode==HLT, the next state is HALTED.
- HALTED is absorbing until rst. In HALTED: halt=1, all other strobes 0, phase=4.
- Define ALUOP = opcode in {ADD, AND, XOR, LDA}.
- Strobes asserted per phase (any strobe not listed is 0):
  - P0 INST_ADDR: sel=1.
  - P1 INST_FETCH: sel=1, rd=1.
  - P2 INST_LOAD: sel=1, rd=1, ld_ir=1.
  - P3 IDLE: sel=1, rd=1, ld_ir=1.
  - P4 OP_ADDR: inc_pc=1; halt=(opcode==HLT).
  - P5 OP_FETCH: rd=ALUOP.
  - P6 ALU_OP: rd=ALUOP; inc_pc=(opcode==SKZ && zero); ld_pc=(opcode==JMP); data_e=(opcode==STO).
  - P7 STORE: rd=ALUOP; ld_ac=ALUOP; ld_pc=(opcode==JMP); wr=(opcode==STO); data_e=(opcode==STO).
- SKZ skip: zero is sampled only in P6. A zero change in any other phase has no effect.
- Latency: 8 clocks per instruction; HLT reaches HALTED 5 clocks after P0.
- instr_count:
  - Increments by 1 on the P7->P0 transition.
  - Wraps from 2^CNT_W-1 to 0.
  - Not incremented for HLT.
  - Frozen in HALTED.
  - If rst is asserted in P7, the reset wins: count<=0.
- ld_pc and inc_pc are never both 1 in the same phase.
- wr implies data_e.

Decomposition:
- Package risc_pkg holds:
  - opcode constants (3-bit, encodings above), shared with the ALU;
  - phase encodings P0..P7 (3-bit) and HALTED;
  - the ALUOP membership function.
- Sub-module risc_phase_counter holds the 3-bit phase register with its advance/halt/reset logic.
- risc_controller keeps the output decode and instr_count.

Test Plan:
- Reset, then run ADD (opcode=010, zero=0) for 8 clocks:
  - P0-P3: sel=1; rd=1 in P1-P3; ld_ir=1 in P2-P3.
  - P4: inc_pc=1.
  - P5-P7: rd=1.
  - P7: ld_ac=1.
  - Back at P0: instr_count=1.
- SKZ (001) with zero=1 in P6 -> inc_pc=1 in P4 and P6. Repeat with zero=0 -> inc_pc only in P4. Toggling zero in P5/P7 changes nothing.
- STO (110):
  - P6: data_e=1, wr=0.
  - P7: data_e=1, wr=1, ld_ac=0, rd=0.
- JMP (111) -> ld_pc=1 in P6 and P7; inc_pc=1 only in P4.
- HLT (000):
  - P4: halt=1, inc_pc=1.
  - Next cycle: HALTED with halt=1, phase=4, all strobes 0 for 20 clocks; instr_count unchanged.
  - Assert rst -> P0 with sel=1, count=0.
- Wrap and reset:
  - Run 256 ADDs -> instr_count 255->0.
  - Assert rst during P5 -> next cycle phase=0, count=0, no ld_ac pulse.
